ap_detector: RTL and testbench
==============================

# ap_detector

Registered arithmetic-progression detector. It samples seven WIDTH-bit unsigned terms, a..g, on a valid strobe. One cycle later it reports whether the terms form an arithmetic progression modulo 2^WIDTH, along with the common difference. It is a leaf datapath block with no backpressure and a fixed one-cycle latency.

## Interface
- WIDTH, 8, bit width of every term and of the difference output.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  a..g are sampled at this edge when high.
- a  input  WIDTH  term 0.
- b  input  WIDTH  term 1.
- c  input  WIDTH  term 2.
- d  input  WIDTH  term 3.
- e  input  WIDTH  term 4.
- f  input  WIDTH  term 5.
- g  input  WIDTH  term 6.
- out_valid  output  1  high for exactly one cycle per accepted input set.
- is_ap  output  1  1 when the accepted set is an arithmetic progression.
- diff  output  WIDTH  common difference (b - a) mod 2^WIDTH of the accepted set.

## Operation
- Six consecutive differences, each computed as WIDTH-bit unsigned subtraction (wrap, no carry out):
  - d0 = b-a
  - d1 = c-b
  - d2 = d-c
  - d3 = e-d
  - d4 = f-e
  - d5 = g-f
- is_ap = (d0==d1) && (d1==d2) && (d2==d3) && (d3==d4) && (d4==d5).
- Equivalent requirement: every term equals a + k·d0 modulo 2^WIDTH, for k = 0..6.
- Arithmetic is strictly modulo 2^WIDTH:
  - Sequences that overflow past 2^WIDTH-1 still qualify. Example: 30,70,110,150,190,230,14 is an AP with diff 40.
  - Sequences that underflow past 0 still qualify.
  - Descending progressions qualify. diff is then the two's-complement encoding, e.g. step -5 gives diff = 8'hFB.
- Constant sequences, including all-zero and all-0xFF, qualify with diff = 0.
- diff is computed and reported even when is_ap = 0. It is always b - a.
- No X-propagation masking; inputs are assumed known when in_valid is high.

## Timing
- Latency is 1 cycle:
  - a..g are sampled at edge N with in_valid = 1.
  - is_ap, diff and out_valid = 1 are presented after edge N and stay stable until edge N+1.
- Throughput: one input set per cycle. in_valid may stay high continuously, and each cycle produces an independent result.
- in_valid = 0 at an edge:
  - out_valid goes to 0 after that edge.
  - is_ap and diff hold their previous values.
- Reset:
  - rst high at an edge forces out_valid = 0, is_ap = 0 and diff = 0 after that edge, regardless of in_valid.
  - An input set sampled coincident with reset is discarded.
  - An input accepted the cycle before reset asserts still produces its result. Reset then clears it at the following edge.
- Outputs come directly from flops; there is no combinational input-to-output path.

## Test plan
- Reset: assert rst for 2 cycles while in_valid = 1 with AP data -> out_valid = 0, is_ap = 0, diff = 0 throughout. First result appears 1 cycle after the first non-reset accept.
- Directed APs:
  - 1,2,3,4,5,6,7 -> is_ap = 1, diff = 1.
  - 5,10,15,20,25,30,35 -> is_ap = 1, diff = 5.
  - All terms 0x2A -> is_ap = 1, diff = 0.
- Non-APs:
  - 0,5,7,8,10,13,3 -> is_ap = 0, diff = 5.
  - 1,6,7,8,10,13,3 -> is_ap = 0.
  - 2,4,8,16,32,64,128 -> is_ap = 0, diff = 2.
  - 17,5,4,11,17,6,7 -> is_ap = 0.
- Wrap and descending:
  - 30,70,110,150,190,230,14 -> is_ap = 1, diff = 40.
  - 250,245,240,235,230,225,220 -> is_ap = 1, diff = 0xFB.
- Streaming: back-to-back valid sets, AP then non-AP then AP -> out_valid stays high, is_ap = 1,0,1 each one cycle late. Then drop in_valid -> out_valid = 0 and is_ap holds at 1.
- Random:
  - 100 random sets checked against a modulo-256 difference model.
  - 100 constant sets, expecting is_ap = 1.
  - 100 generated APs (a in 10..255, step ±0..40, terms truncated to 8 bits), expecting is_ap = 1 every time.

Source files
------------

// File: rtl/ap_detector.sv
// Registered arithmetic-progression detector over seven WIDTH-bit terms.
// One-cycle latency, modulo 2^WIDTH arithmetic, results held while idle.
module ap_detector #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    output logic             out_valid,
    output logic             is_ap,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH-1:0] w_d0;
    logic [WIDTH-1:0] w_d1;
    logic [WIDTH-1:0] w_d2;
    logic [WIDTH-1:0] w_d3;
    logic [WIDTH-1:0] w_d4;
    logic [WIDTH-1:0] w_d5;
    logic             w_is_ap;

    logic             r_out_valid;
    logic             r_is_ap;
    logic [WIDTH-1:0] r_diff;

    // Consecutive differences wrap naturally at WIDTH bits.
    assign w_d0 = b - a;
    assign w_d1 = c - b;
    assign w_d2 = d - c;
    assign w_d3 = e - d;
    assign w_d4 = f - e;
    assign w_d5 = g - f;

    assign w_is_ap = (w_d0 == w_d1) && (w_d1 == w_d2) && (w_d2 == w_d3) &&
                     (w_d3 == w_d4) && (w_d4 == w_d5);

    // Result registers; is_ap/diff hold when no new set is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_is_ap     <= 1'b0;
            r_diff      <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_is_ap <= w_is_ap;
                r_diff  <= w_d0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign is_ap     = r_is_ap;
    assign diff      = r_diff;

endmodule

// File: tb/tb_ap_detector.sv
// Self-checking bench for ap_detector: directed, streaming, reset and random
// sets, with expected results queued at drive time and popped on output.
module tb_ap_detector;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             is_ap;
        logic [WIDTH-1:0] diff;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a, b, c, d, e, f, g;
    logic             out_valid;
    logic             is_ap;
    logic [WIDTH-1:0] diff;

    exp_t             sb_q[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    logic             drv_valid;
    logic             drv_rst;
    logic             hold_ap;
    logic [WIDTH-1:0] hold_diff;

    ap_detector #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .out_valid(out_valid), .is_ap(is_ap), .diff(diff)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: every term must equal a + k*step modulo 2^WIDTH.
    function automatic exp_t model(input logic [6:0][WIDTH-1:0] t);
        exp_t r;
        r.diff  = WIDTH'(t[1] - t[0]);
        r.is_ap = 1'b1;
        for (int k = 0; k < 7; k++)
            if (t[k] !== WIDTH'(int'(t[0]) + k * int'(r.diff))) r.is_ap = 1'b0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic r, input logic [6:0][WIDTH-1:0] t);
        rst = r; in_valid = v;
        a = t[0]; b = t[1]; c = t[2]; d = t[3]; e = t[4]; f = t[5]; g = t[6];
        drv_valid = v; drv_rst = r;
        if (v && !r) sb_q.push_back(model(t));
    endtask

    task automatic tick(input string tag);
        exp_t ex;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(drv_valid && !drv_rst));
        if (drv_rst) begin
            hold_ap = 1'b0; hold_diff = '0;
        end else if (drv_valid) begin
            n_assert++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL %s.queue: observed empty expected entry", tag);
            end
            if (sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                hold_ap = ex.is_ap; hold_diff = ex.diff;
            end
        end
        check({tag, ".is_ap"}, WIDTH'(is_ap), WIDTH'(hold_ap));
        check({tag, ".diff"}, diff, hold_diff);
    endtask

    task automatic run(input string tag, input logic [6:0][WIDTH-1:0] t);
        drive(1'b1, 1'b0, t);
        tick(tag);
    endtask

    function automatic logic [6:0][WIDTH-1:0] mk(input int t0, t1, t2, t3, t4, t5, t6);
        logic [6:0][WIDTH-1:0] t;
        t[0] = WIDTH'(t0); t[1] = WIDTH'(t1); t[2] = WIDTH'(t2); t[3] = WIDTH'(t3);
        t[4] = WIDTH'(t4); t[5] = WIDTH'(t5); t[6] = WIDTH'(t6);
        return t;
    endfunction

    initial begin
        logic [6:0][WIDTH-1:0] t;
        int base;
        int step;
        hold_ap = 1'b0; hold_diff = '0;

        // Reset with valid AP data present: nothing accepted.
        drive(1'b1, 1'b1, mk(1, 2, 3, 4, 5, 6, 7));
        tick("rst0");
        tick("rst1");

        // Directed sets; explicit spec values checked alongside the model.
        run("ap_1", mk(1, 2, 3, 4, 5, 6, 7));
        check("ap_1.spec_ap", WIDTH'(is_ap), 8'd1);
        check("ap_1.spec_diff", diff, 8'd1);
        run("ap_5", mk(5, 10, 15, 20, 25, 30, 35));
        check("ap_5.spec_diff", diff, 8'd5);
        run("const2a", mk(42, 42, 42, 42, 42, 42, 42));
        check("const2a.spec_ap", WIDTH'(is_ap), 8'd1);
        run("nap_a", mk(0, 5, 7, 8, 10, 13, 3));
        check("nap_a.spec_ap", WIDTH'(is_ap), 8'd0);
        check("nap_a.spec_diff", diff, 8'd5);
        run("nap_b", mk(1, 6, 7, 8, 10, 13, 3));
        run("geo", mk(2, 4, 8, 16, 32, 64, 128));
        check("geo.spec_ap", WIDTH'(is_ap), 8'd0);
        run("nap_c", mk(17, 5, 4, 11, 17, 6, 7));
        run("nap_last", mk(1, 2, 3, 4, 5, 6, 8));
        check("nap_last.spec_ap", WIDTH'(is_ap), 8'd0);
        run("wrap", mk(30, 70, 110, 150, 190, 230, 14));
        check("wrap.spec_ap", WIDTH'(is_ap), 8'd1);
        check("wrap.spec_diff", diff, 8'd40);
        run("desc", mk(250, 245, 240, 235, 230, 225, 220));
        check("desc.spec_diff", diff, 8'hFB);
        run("zero", mk(0, 0, 0, 0, 0, 0, 0));
        run("ff", mk(255, 255, 255, 255, 255, 255, 255));
        check("ff.spec_ap", WIDTH'(is_ap), 8'd1);

        // Streaming AP / non-AP / AP, then idle holds the last result.
        run("str0", mk(3, 6, 9, 12, 15, 18, 21));
        run("str1", mk(3, 6, 9, 12, 15, 18, 22));
        run("str2", mk(9, 7, 5, 3, 1, 255, 253));
        drive(1'b0, 1'b0, mk(0, 5, 7, 8, 10, 13, 3));
        tick("idle0");
        check("idle0.spec_ap", WIDTH'(is_ap), 8'd1);
        tick("idle1");

        // Accept right before reset: result appears, then reset clears it.
        run("prerst", mk(7, 9, 11, 13, 15, 17, 19));
        drive(1'b1, 1'b1, mk(1, 2, 3, 4, 5, 6, 7));
        tick("rst_clr");
        run("postrst", mk(100, 90, 80, 70, 60, 50, 40));

        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 7; k++) t[k] = WIDTH'($urandom_range(0, 255));
            run("rnd", t);
        end
        for (int i = 0; i < 100; i++) begin
            base = int'($urandom_range(0, 255));
            run("rconst", mk(base, base, base, base, base, base, base));
            check("rconst.spec_ap", WIDTH'(is_ap), 8'd1);
        end
        for (int i = 0; i < 100; i++) begin
            base = int'($urandom_range(10, 255));
            step = int'($urandom_range(0, 80)) - 40;
            run("rgen", mk(base, base + step, base + 2 * step, base + 3 * step,
                           base + 4 * step, base + 5 * step, base + 6 * step));
            check("rgen.spec_ap", WIDTH'(is_ap), 8'd1);
        end

        drive(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
